// File: rtl/i2c_line_filter.sv
// i2c_line_filter
//   Input conditioner for the raw SCL/SDA levels coming from the I2C pad cell.
//   Each line goes through a synchroniser chain and then a stability filter.
//   The filtered levels produce registered one-cycle strobes for SCL edges,
//   START and STOP, and a bus-busy flag.
//   Compile-time option: define I2C_BUS_TIMEOUT_EN to add an SCL-low bus
//   timeout. Without it, bus_timeout is tied low and TIMEOUT_CYC has no effect.
module i2c_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_o,
  output logic sda_o,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic bus_busy,
  output logic bus_timeout
);

  localparam int CNT_W      = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
  localparam int SETTLE_CYC = SYNC_STAGES + FILT_CYC + 1;
  localparam int SET_W      = $clog2(SETTLE_CYC + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYC - 1);
  localparam logic [SET_W-1:0] SET_DONE = SET_W'(SETTLE_CYC);

  // Reject parameter values the structure cannot support.
  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("i2c_line_filter: SYNC_STAGES must be at least 2");
    end
    if (FILT_CYC < 1) begin : g_bad_filt
      $error("i2c_line_filter: FILT_CYC must be at least 1");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("i2c_line_filter: TIMEOUT_CYC must be at least 1");
    end
  endgenerate

  // Bit 0 carries SCL and bit 1 carries SDA throughout the module.
  logic [1:0] w_raw;
  logic [1:0] w_filt;

  assign w_raw = {sda_i, scl_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      logic [SYNC_STAGES-1:0] r_sync;
      logic [CNT_W-1:0]       r_cnt;
      logic                   r_filt;
      logic                   w_s;

      assign w_s = r_sync[SYNC_STAGES-1];

      // Move the asynchronous pad level through the synchroniser chain.
      // The chain resets high, which is the idle level of an I2C bus.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sync <= '1;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[gi]};
        end
      end

      // A new level is accepted only after it has differed from the
      // filtered output on FILT_CYC consecutive cycles. Any cycle on which
      // the line agrees with the output restarts the count.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt  <= '0;
          r_filt <= 1'b1;
        end else if (w_s == r_filt) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_filt <= w_s;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      assign w_filt[gi] = r_filt;
    end
  endgenerate

  // Event detection on filtered levels.
  logic [1:0]       r_prev;
  logic [SET_W-1:0] r_settle;
  logic             w_settled;
  logic             w_rise;
  logic             w_fall;
  logic             w_start;
  logic             w_stop;
  logic             w_scl_hold_high;
  logic             r_scl_rise;
  logic             r_scl_fall;
  logic             r_start;
  logic             r_stop;
  logic             r_busy;
  logic             w_to_hit;

  assign w_settled       = (r_settle == SET_DONE);
  assign w_scl_hold_high = r_prev[0] & w_filt[0];
  assign w_rise          = ~r_prev[0] &  w_filt[0];
  assign w_fall          =  r_prev[0] & ~w_filt[0];
  // START and STOP need SCL high on both samples. This also means that an SDA
  // change landing in the same cycle as an SCL change is not a bus condition.
  assign w_start         =  r_prev[1] & ~w_filt[1] & w_scl_hold_high;
  assign w_stop          = ~r_prev[1] &  w_filt[1] & w_scl_hold_high;

  // Count the cycles after reset release until the pipeline holds real line
  // data. The counter then saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_settle <= '0;
    end else if (!w_settled) begin
      r_settle <= r_settle + SET_W'(1);
    end
  end

  // Keep the previous filtered levels for edge comparison.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= 2'b11;
    end else begin
      r_prev <= w_filt;
    end
  end

  // Registered one-cycle strobes. They stay masked until the settle counter
  // saturates, so lines held low through reset produce no false events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_rise <= 1'b0;
      r_scl_fall <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
    end else begin
      r_scl_rise <= w_settled & w_rise;
      r_scl_fall <= w_settled & w_fall;
      r_start    <= w_settled & w_start;
      r_stop     <= w_settled & w_stop;
    end
  end

`ifdef I2C_BUS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout;
  logic            w_to_run;

  assign w_to_run = r_busy & ~w_filt[0];
  assign w_to_hit = w_to_run & (r_to_cnt == TO_LAST);

  // Measure how long SCL has stayed low while the bus is busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (w_to_run && !w_to_hit) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end else begin
      r_to_cnt <= '0;
    end
  end

  // Produce a one-cycle timeout pulse. It coincides with the forced busy release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_to_hit;
    end
  end

  assign bus_timeout = r_timeout;
`else
  assign w_to_hit    = 1'b0;
  assign bus_timeout = 1'b0;
`endif

  // START sets busy and STOP clears it, on the same edge that raises the
  // matching strobe. A timeout also drops busy. After a timeout, only a new
  // START makes the bus busy again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
    end else if (w_to_hit) begin
      r_busy <= 1'b0;
    end else if (w_settled && w_start) begin
      r_busy <= 1'b1;
    end else if (w_settled && w_stop) begin
      r_busy <= 1'b0;
    end
  end

  assign scl_o     = w_filt[0];
  assign sda_o     = w_filt[1];
  assign scl_rise  = r_scl_rise;
  assign scl_fall  = r_scl_fall;
  assign start_det = r_start;
  assign stop_det  = r_stop;
  assign bus_busy  = r_busy;

endmodule

// File: tb/tb_i2c_line_filter.sv
// tb_i2c_line_filter
//   Directed I2C-like sequences and random line-level segments. Every cycle is
//   checked against a reference that stores the raw-level history and derives
//   the outputs from it: the delayed view, the stability runs, and event
//   conditions on the filtered history.
`timescale 1ns/1ps
module tb_i2c_line_filter;

  localparam int S    = 2;
  localparam int F    = 4;
`ifdef I2C_BUS_TIMEOUT_EN
  localparam int TO   = 50;
`else
  localparam int TO   = 1000;
`endif
  localparam int MAXC = 8192;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic scl_i = 1'b1;
  logic sda_i = 1'b1;
  logic scl_o, sda_o, scl_rise, scl_fall, start_det, stop_det, bus_busy, bus_timeout;

  always #5 clk = ~clk;

  i2c_line_filter #(
    .SYNC_STAGES(S),
    .FILT_CYC   (F),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .scl_o      (scl_o),
    .sda_o      (sda_o),
    .scl_rise   (scl_rise),
    .scl_fall   (scl_fall),
    .start_det  (start_det),
    .stop_det   (stop_det),
    .bus_busy   (bus_busy),
    .bus_timeout(bus_timeout)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int k     = 0;   // clock edges since the last reset release

  // Reference state: raw input history and filtered history, indexed by edge.
  bit raw_s [0:MAXC-1];
  bit raw_d [0:MAXC-1];
  bit hf_s  [0:MAXC-1];
  bit hf_d  [0:MAXC-1];
  bit fs, fd;
  int run_s, run_d;
  bit m_busy;
  int to_run;
  int n_start, n_stop, n_rise;

  task automatic check(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s edge=%0d got=%b exp=%b", tag, k, got, exp);
    end
  endtask

  function automatic bit filt_scl(input int i);
    return (i <= 0) ? 1'b1 : hf_s[i];
  endfunction

  function automatic bit filt_sda(input int i);
    return (i <= 0) ? 1'b1 : hf_d[i];
  endfunction

  // Apply one cycle of pad levels. Update the reference for that edge and
  // compare every output.
  task automatic step(input bit scl, input bit sda);
    bit v_s, v_d, a_s, b_s, a_d, b_d, en;
    bit e_rise, e_fall, e_start, e_stop, e_to;
    scl_i = scl;
    sda_i = sda;
    @(posedge clk);
    k++;
    if (k >= MAXC) begin
      $display("FAIL model_overflow edge=%0d got=%0d exp<%0d", k, k, MAXC);
      $fatal(1, "history overflow");
    end
    raw_s[k] = scl;
    raw_d[k] = sda;
    // The filter sees the pad level from S edges earlier. The lines idle
    // high before the first edge.
    v_s = (k - S >= 1) ? raw_s[k - S] : 1'b1;
    v_d = (k - S >= 1) ? raw_d[k - S] : 1'b1;
    // A differing level must hold for F consecutive edges before it is accepted.
    if (v_s != fs) begin
      run_s++;
      if (run_s == F) begin fs = v_s; run_s = 0; end
    end else run_s = 0;
    if (v_d != fd) begin
      run_d++;
      if (run_d == F) begin fd = v_d; run_d = 0; end
    end else run_d = 0;
    hf_s[k] = fs;
    hf_d[k] = fd;
    // A strobe reports the change between the two filtered samples before
    // this edge. Strobes are masked for the first S+F+1 edges.
    a_s = filt_scl(k - 2);
    b_s = filt_scl(k - 1);
    a_d = filt_sda(k - 2);
    b_d = filt_sda(k - 1);
    en      = (k >= S + F + 2);
    e_rise  = en && !a_s && b_s;
    e_fall  = en && a_s && !b_s;
    e_start = en && a_s && b_s && a_d && !b_d;
    e_stop  = en && a_s && b_s && !a_d && b_d;
    e_to    = 1'b0;
`ifdef I2C_BUS_TIMEOUT_EN
    if (m_busy && !b_s) begin
      to_run++;
      if (to_run == TO) begin e_to = 1'b1; m_busy = 1'b0; to_run = 0; end
    end else to_run = 0;
`endif
    if (e_start) m_busy = 1'b1;
    else if (e_stop) m_busy = 1'b0;
    n_start += int'(e_start);
    n_stop  += int'(e_stop);
    n_rise  += int'(e_rise);
    #1;
    check("scl_o",       scl_o,       fs);
    check("sda_o",       sda_o,       fd);
    check("scl_rise",    scl_rise,    e_rise);
    check("scl_fall",    scl_fall,    e_fall);
    check("start_det",   start_det,   e_start);
    check("stop_det",    stop_det,    e_stop);
    check("bus_busy",    bus_busy,    m_busy);
    check("bus_timeout", bus_timeout, e_to);
  endtask

  task automatic hold(input bit scl, input bit sda, input int n);
    for (int i = 0; i < n; i++) step(scl, sda);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_scl_o"},   scl_o,       1'b1);
    check({tag, "_sda_o"},   sda_o,       1'b1);
    check({tag, "_rise"},    scl_rise,    1'b0);
    check({tag, "_fall"},    scl_fall,    1'b0);
    check({tag, "_start"},   start_det,   1'b0);
    check({tag, "_stop"},    stop_det,    1'b0);
    check({tag, "_busy"},    bus_busy,    1'b0);
    check({tag, "_timeout"}, bus_timeout, 1'b0);
  endtask

  // Assert reset with the given pad levels, then release it between edges
  // and restart the reference history.
  task automatic do_reset(input bit scl, input bit sda, input int cycles);
    rst   = 1'b1;
    scl_i = scl;
    sda_i = sda;
    #1;
    check_reset_values("rst_assert");
    repeat (cycles) @(posedge clk);
    #1;
    check_reset_values("rst_hold");
    rst    = 1'b0;
    k      = 0;
    fs     = 1'b1;
    fd     = 1'b1;
    run_s  = 0;
    run_d  = 0;
    m_busy = 1'b0;
    to_run = 0;
  endtask

  task automatic random_segments(input int n);
    int lv, len;
    for (int i = 0; i < n; i++) begin
      lv  = int'($urandom_range(0, 3));
      len = int'($urandom_range(1, 12));
      hold(lv[0], lv[1], len);
    end
  endtask

  initial begin
    bit cur_sda, nxt_sda;
    n_start = 0;
    n_stop  = 0;
    n_rise  = 0;
    #3;
    do_reset(1'b1, 1'b1, 3);
    hold(1'b1, 1'b1, 12);
    $display("txn idle_after_reset edges=%0d busy=%b", k, bus_busy);

    hold(1'b1, 1'b0, 3);
    hold(1'b1, 1'b1, 12);
    $display("txn sda_glitch_3clk sda_o=%b start=%0d", sda_o, n_start);

    hold(1'b1, 1'b0, 20);
    $display("txn start busy=%b start=%0d", bus_busy, n_start);

    cur_sda = 1'b0;
    for (int b = 0; b < 8; b++) begin
      nxt_sda = 1'($urandom_range(0, 1));
      hold(1'b0, cur_sda, 4);
      hold(1'b0, nxt_sda, 12);
      hold(1'b1, nxt_sda, 16);
      cur_sda = nxt_sda;
    end
    $display("txn eight_scl_pulses rises=%0d busy=%b", n_rise, bus_busy);

    hold(1'b0, 1'b0, 16);
    hold(1'b1, 1'b0, 16);
    hold(1'b1, 1'b1, 20);
    $display("txn stop busy=%b stop=%0d", bus_busy, n_stop);

    hold(1'b0, 1'b1, 16);
    hold(1'b0, 1'b0, 16);
    hold(1'b1, 1'b0, 16);
    hold(1'b1, 1'b1, 20);
    $display("txn stop_while_idle busy=%b stop=%0d", bus_busy, n_stop);

    hold(1'b0, 1'b0, 20);
    hold(1'b1, 1'b1, 20);
    hold(1'b0, 1'b0, 20);
    hold(1'b1, 1'b1, 20);
    $display("txn same_cycle_scl_sda start=%0d stop=%0d", n_start, n_stop);

`ifdef I2C_BUS_TIMEOUT_EN
    hold(1'b1, 1'b0, 20);
    hold(1'b0, 1'b0, 80);
    hold(1'b0, 1'b1, 10);
    hold(1'b1, 1'b1, 20);
    $display("txn scl_low_timeout busy=%b", bus_busy);
`endif

    random_segments(300);
    $display("txn random_a start=%0d stop=%0d rises=%0d", n_start, n_stop, n_rise);

    hold(1'b1, 1'b0, 20);
    do_reset(1'b0, 1'b0, 4);
    hold(1'b0, 1'b0, 20);
    hold(1'b1, 1'b1, 20);
    $display("txn reset_mid_transfer_lines_low busy=%b", bus_busy);

    random_segments(200);
    $display("txn random_b start=%0d stop=%0d rises=%0d", n_start, n_stop, n_rise);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
